ksa_shuffle: RTL and testbench

KSA_SHUFFLE -- requirements
Module: ksa_shuffle

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/key_byte_sel.sv | 22 ++
 rtl/ksa_shuffle.sv | 127 ++++++++++++
 tb/tb_ksa_shuffle.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding, memory-select codes, default key length.
package rc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_READ_I,
      ST_WAIT_I,
      ST_CALC_J,
      ST_READ_J,
      ST_WAIT_J,
      ST_LATCH_J,
      ST_WRITE_I,
      ST_WRITE_J,
      ST_DONE
   } ksa_state_t;

   localparam logic [1:0] MEM_SEL_WORKING = 2'b01;
   localparam logic [1:0] MEM_SEL_NONE    = 2'b00;

   localparam int KEY_BYTES_DEFAULT = 3;

endpackage

// File: rtl/key_byte_sel.sv
// Picks key byte idx out of secret_key (byte 0 is the most significant byte).
// Purely combinational; an out-of-range idx yields 0.
module key_byte_sel
   import rc4_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             idx,
   output logic [7:0]             key_byte
);

   always_comb begin
      key_byte = '0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (idx == b[7:0]) begin
            key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
         end
      end
   end

endmodule

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling shuffle over a 256-byte working RAM with READ_LAT-cycle reads.
// Iteration = 2 reads + 2 writes (8 cycles at READ_LAT=2); dropping start aborts to IDLE.
module ksa_shuffle
   import rc4_pkg::*;
#(
   parameter int READ_LAT  = 2,
   parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             q_shuffle,
   output logic [7:0]             address,
   output logic [7:0]             data,
   output logic                   wren,
   output logic [1:0]             mem_sel,
   output logic                   busy,
   output logic                   done
);

   localparam logic [7:0] WAIT_LAST = 8'((READ_LAT > 1) ? (READ_LAT - 2) : 0);
   localparam logic [7:0] KEY_LAST  = 8'(KEY_BYTES - 1);

   ksa_state_t state, state_n;
   logic [7:0] i, j, si, sj;
   logic [7:0] kidx;
   logic [7:0] wait_cnt;
   logic [7:0] key_byte;
   logic       in_busy;

   key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_byte_sel (
      .secret_key (secret_key),
      .idx        (kidx),
      .key_byte   (key_byte)
   );

   assign in_busy = (state != ST_IDLE) && (state != ST_DONE);

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:    if (start) state_n = ST_READ_I;
         ST_READ_I:  state_n = (READ_LAT > 1) ? ST_WAIT_I : ST_CALC_J;
         ST_WAIT_I:  if (wait_cnt == WAIT_LAST) state_n = ST_CALC_J;
         ST_CALC_J:  state_n = ST_READ_J;
         ST_READ_J:  state_n = (READ_LAT > 1) ? ST_WAIT_J : ST_LATCH_J;
         ST_WAIT_J:  if (wait_cnt == WAIT_LAST) state_n = ST_LATCH_J;
         ST_LATCH_J: state_n = ST_WRITE_I;
         ST_WRITE_I: state_n = ST_WRITE_J;
         ST_WRITE_J: state_n = (i == 8'hFF) ? ST_DONE : ST_READ_I;
         ST_DONE:    if (!start) state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
      // Losing the grant mid-shuffle abandons the run outright.
      if (in_busy && !start) state_n = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         i        <= '0;
         j        <= '0;
         si       <= '0;
         sj       <= '0;
         kidx     <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_n;
         if (state == ST_WAIT_I || state == ST_WAIT_J) wait_cnt <= wait_cnt + 8'd1;
         else                                          wait_cnt <= '0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  i    <= '0;
                  j    <= '0;
                  kidx <= '0;
               end
            end
            ST_CALC_J: begin
               si <= q_shuffle;
               j  <= j + q_shuffle + key_byte;
            end
            ST_LATCH_J: sj <= q_shuffle;
            ST_WRITE_J: begin
               if (i != 8'hFF) begin
                  i    <= i + 8'd1;
                  kidx <= (kidx == KEY_LAST) ? 8'd0 : kidx + 8'd1;
               end
            end
            default: ;
         endcase
         if (in_busy && !start) begin
            i    <= '0;
            j    <= '0;
            kidx <= '0;
         end
      end
   end

   // Both reads of an iteration land before either write, so i==j needs no special case.
   always_comb begin
      address = '0;
      data    = '0;
      wren    = 1'b0;
      case (state)
         ST_READ_I, ST_WAIT_I: address = i;
         ST_READ_J, ST_WAIT_J: address = j;
         ST_WRITE_I: begin
            address = i;
            data    = sj;
            wren    = 1'b1;
         end
         ST_WRITE_J: begin
            address = j;
            data    = si;
            wren    = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_sel = (state == ST_IDLE) ? MEM_SEL_NONE : MEM_SEL_WORKING;
   assign busy    = in_busy;
   assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: 2-cycle RAM model, write scoreboard fed by a software KSA model.
module tb_ksa_shuffle;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  q_shuffle;
   logic [7:0]  address;
   logic [7:0]  data;
   logic        wren;
   logic [1:0]  mem_sel;
   logic        busy;
   logic        done;

   ksa_shuffle #(.READ_LAT(2), .KEY_BYTES(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .secret_key (secret_key),
      .q_shuffle  (q_shuffle),
      .address    (address),
      .data       (data),
      .wren       (wren),
      .mem_sel    (mem_sel),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wr_count = 0;

   logic [7:0]  ram [256];
   logic [7:0]  load_img [256];
   logic [7:0]  gm [256];
   logic        load = 1'b0;
   logic [7:0]  p1 = '0;
   logic [7:0]  p2 = '0;
   logic [15:0] exp_q [$];
   logic [15:0] wr_log [4096];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (load) begin
         for (int k = 0; k < 256; k++) ram[k] <= load_img[k];
      end else if (wren) begin
         ram[address] <= data;
      end
      p1 <= ram[address];
      p2 <= p1;
   end
   assign q_shuffle = p2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!load && wren === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h:%0h required=none", address, data);
         end else begin
            check("write_addr_data", {16'd0, address, data}, {16'd0, exp_q.pop_front()});
         end
         if (wr_count < 4096) wr_log[wr_count] = {address, data};
         wr_count++;
      end
   end

   task automatic model(input logic [23:0] key, input int n);
      logic [7:0] j;
      logic [7:0] t;
      logic [7:0] ib;
      j = 8'd0;
      for (int ii = 0; ii < n; ii++) begin
         ib = ii[7:0];
         j  = j + gm[ib] + key[8*(2-(ii%3)) +: 8];
         t  = gm[ib];
         exp_q.push_back({ib, gm[j]});
         exp_q.push_back({j, t});
         gm[ib] = gm[j];
         gm[j]  = t;
      end
   endtask

   task automatic load_identity();
      for (int k = 0; k < 256; k++) begin
         gm[k]       = k[7:0];
         load_img[k] = k[7:0];
      end
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input string name, input int t0);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 3000);
      check(name, cyc - t0, 2049);
   endtask

   task automatic check_final(input string name);
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) if (ram[k] !== gm[k]) bad++;
      check(name, bad, 0);
   endtask

   initial begin
      int t0;
      int base;
      reset      = 1'b1;
      start      = 1'b0;
      secret_key = 24'h000000;
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", {11'd0, address, data, wren, mem_sel, busy, done}, 32'd0);
      reset = 1'b0;

      // Run 1: all-zero key, then hold in DONE and release.
      load_identity();
      model(24'h000000, 256);
      base  = wr_count;
      start = 1'b1;
      t0    = cyc;
      wait_done("run1_done_latency", t0);
      check("run1_write_count", wr_count - base, 512);
      check_final("run1_final_s");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("done_hold", {30'd0, done, wren}, 32'b10);
      end
      start = 1'b0;
      @(negedge clk);
      check("done_release", {28'd0, done, busy, mem_sel}, 32'd0);

      // Run 2: key 000249 with hand-computed first iterations.
      secret_key = 24'h000249;
      load_identity();
      model(secret_key, 256);
      base  = wr_count;
      start = 1'b1;
      t0    = cyc;
      wait_done("run2_done_latency", t0);
      check("run2_write_count", wr_count - base, 512);
      check("run2_w0", wr_log[base],     16'h0000);
      check("run2_w1", wr_log[base + 1], 16'h0000);
      check("run2_w2", wr_log[base + 2], 16'h0103);
      check("run2_w3", wr_log[base + 3], 16'h0301);
      check_final("run2_final_s");
      start = 1'b0;
      @(negedge clk);

      // Run 3: abort at T+100 (12 whole iterations done), then full restart.
      load_identity();
      model(secret_key, 12);
      base  = wr_count;
      start = 1'b1;
      t0    = cyc;
      repeat (100) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_outputs", {28'd0, wren, mem_sel, done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_write_count", wr_count - base, 24);
      check("abort_queue_empty", exp_q.size(), 0);
      model(secret_key, 256);
      base  = wr_count;
      start = 1'b1;
      t0    = cyc;
      wait_done("restart_done_latency", t0);
      check("restart_write_count", wr_count - base, 512);
      check_final("restart_final_s");
      start = 1'b0;
      @(negedge clk);

      // Run 4: one-cycle reset at T+500 (62 whole iterations done), start held.
      load_identity();
      model(secret_key, 62);
      base  = wr_count;
      start = 1'b1;
      t0    = cyc;
      repeat (500) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrun_reset_outputs", {11'd0, address, data, wren, mem_sel, busy, done}, 32'd0);
      check("midrun_reset_write_count", wr_count - base, 124);
      check("midrun_reset_queue_empty", exp_q.size(), 0);
      model(secret_key, 256);
      base = wr_count;
      t0   = cyc;
      wait_done("post_reset_done_latency", t0);
      check("post_reset_write_count", wr_count - base, 512);
      check_final("post_reset_final_s");
      start = 1'b0;
      @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
